// File: rtl/dmem_unit.sv
// Data-side memory stage: a 128-word RAM that is cleared after reset, plus OUT, CYC and WCNT registers
// mapped at the top of the address space. All state updates on the falling edge of CK.
module dmem_unit #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int WIDTH = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [15:0]      DA,
    inout  wire  [WIDTH-1:0] DD,
    input  logic             RW,
    output logic [WIDTH-1:0] OUT,
    output logic             BUSY
);

    localparam logic [AW-1:0] A_OUT  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] A_CYC  = AW'(DEPTH - 2);
    localparam logic [AW-1:0] A_WCNT = AW'(DEPTH - 3);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     cp, cp_nx;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  cyc, wcnt, rd;
    logic [AW-1:0]     addr;
    logic              ram_we;
    logic [AW-1:0]     ram_wa;
    logic [WIDTH-1:0]  ram_wd;
    logic              unused_da;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Upper address bits are ignored, so addresses alias modulo DEPTH.
    assign addr      = DA[AW-1:0];
    assign unused_da = ^DA[15:AW];

    always_ff @(negedge CK or negedge RST) begin
        if (!RST) begin
            state <= CLEAR;
            cp    <= '0;
        end else begin
            state <= state_nx;
            cp    <= cp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cp_nx    = cp;
        if (state == CLEAR) begin
            cp_nx = cp + 1'b1;
            if (cp == AW'(DEPTH - 1))
                state_nx = RUN;
        end
    end

    assign BUSY = (state == CLEAR);

    // The clear sequencer and CPU writes share the one RAM write port.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = addr;
        ram_wd = DD;
        if (state == CLEAR) begin
            ram_we = RST;
            ram_wa = cp;
            ram_wd = '0;
        end else if (!RW && addr < A_WCNT) begin
            ram_we = RST;
        end
    end

    always_ff @(negedge CK) begin
        if (ram_we)
            mem[ram_wa] <= ram_wd;
    end

    always_ff @(negedge CK or negedge RST) begin
        if (!RST) begin
            OUT  <= '0;
            cyc  <= '0;
            wcnt <= '0;
            rd   <= '0;
        end else begin
            cyc <= cyc + 1'b1;
            if (state == CLEAR) begin
                if (RW)
                    rd <= '0;
            end else if (RW) begin
                // A CYC read returns the value before this edge's increment.
                case (addr)
                    A_OUT:   rd <= OUT;
                    A_CYC:   rd <= cyc;
                    A_WCNT:  rd <= wcnt;
                    default: rd <= mem[addr];
                endcase
            end else begin
                if (addr == A_OUT)
                    OUT <= DD;
                else if (addr < A_WCNT)
                    wcnt <= sat_inc(wcnt);
            end
        end
    end

    assign DD = (RW && RST) ? rd : 'z;

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: directed vector table, hand-written reset/clear sequences and random traffic
// compared against an address-map reference model.
module tb_dmem_unit;

    logic        CK = 1'b1;
    logic        RST = 1'b0;
    logic [15:0] DA = '0;
    logic        RW = 1'b1;
    logic [15:0] OUT;
    logic        BUSY;
    wire  [15:0] DD;
    logic [15:0] drv = '0;
    logic        drv_en = 1'b0;

    assign DD = drv_en ? drv : 16'hzzzz;

    dmem_unit dut (
        .CK   (CK),
        .RST  (RST),
        .DA   (DA),
        .DD   (DD),
        .RW   (RW),
        .OUT  (OUT),
        .BUSY (BUSY)
    );

    always #5 CK = ~CK;

    int checks = 0;
    int errors = 0;

    // Reference model: state as the CPU sees it through the address map.
    logic [15:0] m_mem [128];
    logic [15:0] m_out, m_cyc, m_wcnt, m_rd;
    int          m_edges;

    typedef struct {
        logic        rw;
        logic [15:0] da;
        logic [15:0] wd;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = '0;
        m_out = '0; m_cyc = '0; m_wcnt = '0; m_rd = '0; m_edges = 0;
    endtask

    task automatic model_edge(input logic rw, input logic [15:0] da, input logic [15:0] wd);
        int a;
        a = int'(da) % 128;
        if (m_edges < 128) begin
            if (rw) m_rd = '0;
        end else if (rw) begin
            if (a == 127)      m_rd = m_out;
            else if (a == 126) m_rd = m_cyc;
            else if (a == 125) m_rd = m_wcnt;
            else               m_rd = m_mem[a];
        end else begin
            if (a == 127) m_out = wd;
            else if (a < 125) begin
                m_mem[a] = wd;
                if (m_wcnt != 16'hFFFF) m_wcnt = m_wcnt + 16'd1;
            end
        end
        m_cyc = m_cyc + 16'd1;
        m_edges++;
    endtask

    // One falling-edge access, checked after the edge.
    task automatic step(input logic rw, input logic [15:0] da, input logic [15:0] wd);
        RW = rw; DA = da; drv = wd; drv_en = !rw;
        @(negedge CK);
        model_edge(rw, da, wd);
        #1;
        chk("busy", {15'd0, BUSY}, {15'd0, (m_edges < 128)});
        chk("out", OUT, m_out);
        if (rw) chk("rdata", DD, m_rd);
        else    chk("bus_released", DD, wd);
    endtask

    task automatic quiet_step();
        RW = 1'b1; DA = 16'h0000; drv_en = 1'b0;
        @(negedge CK);
        model_edge(1'b1, 16'h0000, 16'h0000);
        #1;
    endtask

    task automatic do_reset(input int hold_ns);
        RST = 1'b0; drv_en = 1'b0; RW = 1'b1;
        model_reset();
        #1;
        chk("rst_busy", {15'd0, BUSY}, 16'd1);
        chk("rst_out", OUT, 16'h0000);
        #(hold_ns);
        RST = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r1, r3, r5, da_r;
        int a, n;

        tbl[0]  = '{1'b0, 16'h0000, 16'h0004, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0004};
        tbl[2]  = '{1'b1, 16'h007D, 16'h0000, 1'b1, 16'h0001};
        tbl[3]  = '{1'b0, 16'h007F, 16'hBEEF, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 16'h007E, 16'h1234, 1'b0, 16'h0000};
        tbl[5]  = '{1'b1, 16'h007F, 16'h0000, 1'b1, 16'hBEEF};
        tbl[6]  = '{1'b1, 16'h007D, 16'h0000, 1'b1, 16'h0001};
        tbl[7]  = '{1'b0, 16'h0105, 16'hA5A5, 1'b0, 16'h0000};
        tbl[8]  = '{1'b1, 16'h0005, 16'h0000, 1'b1, 16'hA5A5};
        tbl[9]  = '{1'b1, 16'h0085, 16'h0000, 1'b1, 16'hA5A5};
        tbl[10] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'hBEEF};
        tbl[11] = '{1'b1, 16'h007D, 16'h0000, 1'b1, 16'h0002};
        tbl[12] = '{1'b1, 16'h0010, 16'h0000, 1'b1, 16'h0000};

        // Reset and clear, with a write attempted during clear.
        #6;
        do_reset(100);
        step(1'b0, 16'h0003, 16'h5555);
        for (int i = 1; i < 128; i++) step(1'b1, 16'(i), 16'h0000);
        chk("busy_after_clear", {15'd0, BUSY}, 16'd0);
        for (int i = 0; i < 125; i++) step(1'b1, 16'(i), 16'h0000);

        // Directed table from a fresh reset.
        do_reset(100);
        for (int i = 0; i < 128; i++) quiet_step();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rw, tbl[i].da, tbl[i].wd);
            if (tbl[i].chk) chk($sformatf("tbl%0d", i), DD, tbl[i].exp);
        end
        step(1'b1, 16'h007E, 16'h0000);
        chk("cyc_not_1234", {15'd0, (DD == 16'h1234)}, 16'd0);

        // Small CPU program: R5 = R1 + R3, stored to [R0 = 0].
        r1 = 16'd1; r3 = 16'd3; r5 = r1 + r3;
        step(1'b0, 16'h0000, r5);
        step(1'b1, 16'h0000, 16'h0000);
        chk("prog_ld", DD, 16'h0004);

        // Reset in the middle of clearing.
        do_reset(100);
        for (int i = 0; i < 60; i++) step(1'b1, 16'h0000, 16'h0000);
        do_reset(37);
        step(1'b0, 16'h0003, 16'h5555);
        for (int i = 1; i < 128; i++) step(1'b1, 16'h007D, 16'h0000);
        step(1'b1, 16'h0003, 16'h0000);
        chk("midclear_ram", DD, 16'h0000);
        step(1'b1, 16'h007D, 16'h0000);
        chk("midclear_wcnt", DD, 16'h0000);
        step(1'b1, 16'h007E, 16'h0000);
        chk("midclear_cyc", DD, 16'd130);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(0, 3);
            a = (n == 0) ? $urandom_range(125, 127) : $urandom_range(0, 124);
            da_r = {7'($urandom_range(0, 127)), 9'(a)};
            da_r[7] = 1'b0;
            step(1'($urandom_range(0, 1)), da_r, 16'($urandom));
        end

        // Run CYC up to its wrap point.
        n = (65536 - int'(m_cyc) - 2) % 65536;
        for (int i = 0; i < n; i++) quiet_step();
        step(1'b1, 16'h007E, 16'h0000);
        chk("cyc_fffe", DD, 16'hFFFE);
        step(1'b1, 16'h007E, 16'h0000);
        chk("cyc_ffff", DD, 16'hFFFF);
        step(1'b1, 16'h007E, 16'h0000);
        chk("cyc_wrap", DD, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
